// File: rtl/pwm_peripheral_if.sv
// Configuration and pin bundle between the SPI register block (master) and the PWM peripheral (slave).
interface pwm_peripheral_if;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic       period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    input  uo_out, uio_out, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    output uo_out, uio_out, period_start
  );
endinterface

// File: rtl/pwm_peripheral.sv
// Prescaled 8-bit PWM driving 16 pins as forced-low, forced-high or shared PWM.
// Optional macro PWM_DUTY_SHADOW_EN: duty is latched only at the period boundary.
module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  pwm_peripheral_if.slave  bus
);

  localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned PIN_W = 16;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PRE_W-1:0] prescaler;
  logic [CNT_W-1:0] pwm_cnt;
  logic             wrap;
  logic             tick_c;
  logic             boundary_c;
  logic [CNT_W-1:0] duty_c;
  logic             pwm_sig_c;
  logic [PIN_W-1:0] en_out_c;
  logic [PIN_W-1:0] en_pwm_c;
  logic [PIN_W-1:0] pins_c;

  assign tick_c     = (prescaler == PRE_MAX);
  assign boundary_c = tick_c && (pwm_cnt == CNT_MAX);

`ifdef PWM_DUTY_SHADOW_EN
  logic [CNT_W-1:0] duty_shadow;

  // Duty only changes between periods so a running pulse is never cut or stretched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow <= '0;
    end else if (boundary_c) begin
      duty_shadow <= bus.pwm_duty_cycle;
    end
  end

  assign duty_c = duty_shadow;
`else
  assign duty_c = bus.pwm_duty_cycle;
`endif

  // Full-scale duty is forced high so 0xFF has no one-step low gap.
  assign pwm_sig_c = (duty_c == CNT_MAX) || (pwm_cnt < duty_c);

  assign en_out_c = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign en_pwm_c = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
  assign pins_c   = en_out_c & (~en_pwm_c | {PIN_W{pwm_sig_c}});

  // Prescaler, period counter and registered pin stage; period_start trails the wrap by one clk
  // so it lines up with the first pin cycle that reflects pwm_cnt == 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler        <= '0;
      pwm_cnt          <= '0;
      wrap             <= 1'b0;
      bus.uo_out       <= '0;
      bus.uio_out      <= '0;
      bus.period_start <= 1'b0;
    end else begin
      prescaler <= tick_c ? '0 : prescaler + PRE_W'(1);
      if (tick_c) begin
        pwm_cnt <= pwm_cnt + CNT_W'(1);
      end
      wrap             <= boundary_c;
      bus.period_start <= wrap;
      bus.uo_out       <= pins_c[7:0];
      bus.uio_out      <= pins_c[15:8];
    end
  end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
- Downstream consumer of the SPI register block's five configuration registers: output enables, PWM enables and duty cycle.
- Drives the 16 chip outputs: uo_out[7:0] and uio_out[7:0].
- Each output is one of three things: forced low, forced high, or the shared PWM waveform, chosen per bit by the enable registers.
- Contains the clock prescaler, the 8-bit period counter and the registered output stage.

Parameters:
- CLK_DIV, 13, system clocks per PWM counter step; legal range 1..65535. At 10 MHz this gives about 3 kHz PWM (256 steps per period).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- en_reg_out_7_0  input  8  output enables for uo_out[7:0]
- en_reg_out_15_8  input  8  output enables for uio_out[7:0]
- en_reg_pwm_7_0  input  8  PWM mode selects for uo_out[7:0]
- en_reg_pwm_15_8  input  8  PWM mode selects for uio_out[7:0]
- pwm_duty_cycle  input  8  requested duty, 0x00..0xFF
- uo_out  output  8  driven outputs 0..7
- uio_out  output  8  driven outputs 8..15
- period_start  output  1  one-clk pulse when the PWM counter wraps to 0

Behaviour:
- Reset, asynchronous on rst_n low:
  - prescaler = 0, pwm_cnt = 0, active duty = 0.
  - uo_out = 0x00, uio_out = 0x00, period_start = 0.
  - Takes effect immediately, including mid-period. On release, counting restarts from 0.
- Prescaler:
  - Counts 0..CLK_DIV-1. tick = 1 in the clk where prescaler == CLK_DIV-1; the prescaler then wraps to 0.
  - CLK_DIV = 1: tick is asserted every clk.
  - Prescaler width = clog2(CLK_DIV), minimum 1 bit.
- PWM counter:
  - 8-bit pwm_cnt increments on tick; 0xFF wraps to 0x00.
  - Period = 256 * CLK_DIV clks.
- PWM waveform (combinational):
  - pwm_sig = 1 if active duty == 0xFF.
  - Otherwise pwm_sig = (pwm_cnt < active duty), unsigned compare.
  - Duty 0x00 gives constant 0. Duty 0xFF gives constant 1 (no 1/256 glitch).
  - Duty N (1..0xFE) gives N high steps out of 256, high at the start of each period.
- Per-bit select, for i in 0..15, combining en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm likewise:
  - en_out[i] = 0 gives 0, regardless of en_pwm[i].
  - en_out[i] = 1 and en_pwm[i] = 0 gives 1.
  - en_out[i] = 1 and en_pwm[i] = 1 gives pwm_sig.
- Output stage:
  - Result is registered into {uio_out, uo_out}.
  - Latency is one clk from any input/counter change to the pin.
- Enable changes take effect on the next clk, with no period alignment.
- period_start:
  - Registered; asserted for exactly one clk, aligned with the first output cycle of pwm_cnt == 0 after a wrap.
  - Not asserted on the first period after reset.
- Inputs come from the same clock domain; no synchronisers.

Optional Feature:
- PWM_DUTY_SHADOW_EN defined:
  - Active duty is a shadow register, loaded from pwm_duty_cycle only when tick = 1 and pwm_cnt == 0xFF, i.e. at the period boundary.
  - Mid-period duty writes never alter the current period, which gives glitch-free updates.
  - Reset value of the shadow register is 0x00, so PWM outputs stay low until the first boundary after a duty write.
- PWM_DUTY_SHADOW_EN undefined:
  - Active duty = pwm_duty_cycle directly.
  - Changes reach the pins one clk later.
  - A mid-period change may shorten or stretch the current high pulse.

Test Plan:
- Reset: assert rst_n low mid-period with outputs high -> uo_out = uio_out = 0x00 with no clk edge. After release, pwm_cnt restarts at 0 and period_start stays 0 for the first period.
- Static drive: en_out = 0x0001, en_pwm = 0x0000 -> uo_out = 0x01 one clk later, uio_out = 0x00. Then en_out = 0x8000 -> uio_out = 0x80, uo_out = 0x00.
- PWM 50%: CLK_DIV = 1, duty = 0x80, en_out = en_pwm = 0xFFFF -> every pin high for exactly 128 of 256 clks, all 16 pins identical. period_start pulses every 256 clks.
- Duty extremes: duty 0x00 -> pins constantly 0 over 2 periods; duty 0xFF -> constantly 1; duty 0x01 -> exactly 1 high step per period. Repeat with CLK_DIV = 4 -> high time 4 clks.
- Mixed mode: en_out = 0x00FF, en_pwm = 0x000F, duty 0x40 -> uo_out[3:0] toggle 64/256, uo_out[7:4] = 1, uio_out = 0x00.
- Duty update: duty 0x40, change to 0xC0 when pwm_cnt = 0x10:
  - With PWM_DUTY_SHADOW_EN: current period high 64 steps, next period 192.
  - Without: the current pulse extends to 192 steps from period start.
